// File: rtl/si570_freq_sequencer.sv
// si570_freq_sequencer
// Walks the Si570 reprogramming sequence over the i2c_master rv0 (request)
// and rv1 (completion) channels: freeze DCO, write regs 7..12 as two bursts,
// unfreeze, assert NewFreq, then wait out the settle time.
// Optional feature: define SI570_READBACK_EN to read regs 7..12 back after
// NewFreq and flag any byte that differs from what was written.
//
// Handshake rules: a request is offered with o_rv0_valid=1 and every rv0
// field held stable until the cycle i_rv0_ready=1. The sequencer then raises
// o_rv1_ready and waits for the single i_rv1_valid beat of that transaction.
// Only one transaction is ever outstanding. All rv0/rv1 outputs decode from
// registered state only, so no input reaches them combinationally.
module si570_freq_sequencer #(
    parameter logic [6:0]  SlaveAddress  = 7'h5D,
    parameter int unsigned TimeoutCycles = 4096,
    parameter int unsigned SettleCycles  = 2500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_hs_div,
    input  logic [6:0]  i_n1,
    input  logic [37:0] i_rfreq,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_rv0_valid,
    input  logic        i_rv0_ready,
    output logic [6:0]  o_rv0_slave_address,
    output logic [7:0]  o_rv0_reg_address,
    output logic [1:0]  o_rv0_burst_count,
    output logic        o_rv0_rd_wrn,
    output logic [31:0] o_rv0_wdata,
    input  logic        i_rv1_valid,
    output logic        o_rv1_ready,
    input  logic [31:0] i_rv1_rdata
);

    // One counter serves both the handshake timeout and the settle delay.
    localparam int unsigned CntMax = (TimeoutCycles > SettleCycles) ? TimeoutCycles : SettleCycles;
    localparam int          CntW   = $clog2(CntMax) + 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SettleCycles - 1);

    // Each transaction step is split into an explicit REQ and RSP state.
    typedef enum logic [4:0] {
        ST_IDLE,
        ST_FRZ_REQ, ST_FRZ_RSP,
        ST_WRA_REQ, ST_WRA_RSP,
        ST_WRB_REQ, ST_WRB_RSP,
        ST_UNF_REQ, ST_UNF_RSP,
        ST_NF_REQ,  ST_NF_RSP,
        ST_RDA_REQ, ST_RDA_RSP,
        ST_RDB_REQ, ST_RDB_RSP,
        ST_SETTLE,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [2:0]      hs_div_q, hs_div_d;
    logic [6:0]      n1_q, n1_d;
    logic [37:0]     rfreq_q, rfreq_d;

    // Decoded view of the current state.
    logic            req_phase;
    logic            rsp_phase;
    state_e          req_next;
    state_e          rsp_next;
    logic [7:0]      txn_reg;
    logic [1:0]      txn_burst;
    logic            txn_rd;
    logic [31:0]     txn_wdata;

    // Si570 register images built from the latched settings.
    logic [7:0] r7, r8, r9, r10, r11, r12;
    assign r7  = {hs_div_q, n1_q[6:2]};
    assign r8  = {n1_q[1:0], rfreq_q[37:32]};
    assign r9  = rfreq_q[31:24];
    assign r10 = rfreq_q[23:16];
    assign r11 = rfreq_q[15:8];
    assign r12 = rfreq_q[7:0];

    assign o_rv0_slave_address = SlaveAddress;

`ifndef SI570_READBACK_EN
    // Read data is never consumed without the readback steps.
    logic unused_rdata;
    assign unused_rdata = ^i_rv1_rdata;
`endif

    // State, counter, sticky error and latched settings.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            hs_div_q <= '0;
            n1_q     <= '0;
            rfreq_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            hs_div_q <= hs_div_d;
            n1_q     <= n1_d;
            rfreq_q  <= rfreq_d;
        end
    end

    // Step decode, next-state logic and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        hs_div_d  = hs_div_q;
        n1_d      = n1_q;
        rfreq_d   = rfreq_q;
        req_phase = 1'b0;
        rsp_phase = 1'b0;
        req_next  = ST_IDLE;
        rsp_next  = ST_IDLE;
        txn_reg   = 8'h00;
        txn_burst = 2'd0;
        txn_rd    = 1'b0;
        txn_wdata = 32'h0000_0000;

        // What each step puts on rv0 and where it goes next.
        case (state_q)
            ST_FRZ_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_FRZ_RSP;
                txn_reg   = 8'd137;
                txn_wdata = 32'h0000_0010;
            end
            ST_FRZ_RSP: begin
                rsp_phase = 1'b1;
                rsp_next  = ST_WRA_REQ;
            end
            ST_WRA_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_WRA_RSP;
                txn_reg   = 8'd7;
                txn_burst = 2'd3;
                txn_wdata = {r10, r9, r8, r7};
            end
            ST_WRA_RSP: begin
                rsp_phase = 1'b1;
                rsp_next  = ST_WRB_REQ;
            end
            ST_WRB_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_WRB_RSP;
                txn_reg   = 8'd11;
                txn_burst = 2'd1;
                txn_wdata = {16'h0000, r12, r11};
            end
            ST_WRB_RSP: begin
                rsp_phase = 1'b1;
                rsp_next  = ST_UNF_REQ;
            end
            ST_UNF_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_UNF_RSP;
                txn_reg   = 8'd137;
                txn_wdata = 32'h0000_0000;
            end
            ST_UNF_RSP: begin
                rsp_phase = 1'b1;
                rsp_next  = ST_NF_REQ;
            end
            ST_NF_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_NF_RSP;
                txn_reg   = 8'd135;
                txn_wdata = 32'h0000_0040;
            end
            ST_NF_RSP: begin
                rsp_phase = 1'b1;
`ifdef SI570_READBACK_EN
                rsp_next  = ST_RDA_REQ;
`else
                rsp_next  = ST_SETTLE;
`endif
            end
`ifdef SI570_READBACK_EN
            ST_RDA_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_RDA_RSP;
                txn_reg   = 8'd7;
                txn_burst = 2'd3;
                txn_rd    = 1'b1;
            end
            ST_RDA_RSP: begin
                rsp_phase = 1'b1;
                rsp_next  = ST_RDB_REQ;
            end
            ST_RDB_REQ: begin
                req_phase = 1'b1;
                req_next  = ST_RDB_RSP;
                txn_reg   = 8'd11;
                txn_burst = 2'd1;
                txn_rd    = 1'b1;
            end
            ST_RDB_RSP: begin
                rsp_phase = 1'b1;
                rsp_next  = ST_SETTLE;
            end
`endif
            default: begin
            end
        endcase

        // Sequencing; a handshake wins over a timeout on the same cycle.
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (i_start) begin
                hs_div_d = i_hs_div;
                n1_d     = i_n1;
                rfreq_d  = i_rfreq;
                err_d    = 1'b0;
                state_d  = ST_FRZ_REQ;
            end
        end else if (req_phase) begin
            if (i_rv0_ready) begin
                state_d = req_next;
                cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (rsp_phase) begin
            if (i_rv1_valid) begin
                state_d = rsp_next;
                cnt_d   = '0;
`ifdef SI570_READBACK_EN
                if ((state_q == ST_RDA_RSP) && (i_rv1_rdata != {r10, r9, r8, r7})) begin
                    err_d = 1'b1;
                end
                if ((state_q == ST_RDB_RSP) && (i_rv1_rdata[15:0] != {r12, r11})) begin
                    err_d = 1'b1;
                end
`endif
            end else if (cnt_q == TimeoutLast) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q == SettleLast) begin
                state_d = ST_DONE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            // DONE and any unused encoding fall back to IDLE.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        // Outputs depend on registered state only.
        o_rv0_valid       = req_phase;
        o_rv0_reg_address = txn_reg;
        o_rv0_burst_count = txn_burst;
        o_rv0_wdata       = txn_wdata;
`ifdef SI570_READBACK_EN
        o_rv0_rd_wrn      = txn_rd;
`else
        o_rv0_rd_wrn      = 1'b0;
`endif
        o_rv1_ready       = rsp_phase;
        o_busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
        o_done            = (state_q == ST_DONE);
        o_error           = err_q;
    end

endmodule
